uart_mem_loader: RTL and testbench
==================================

Name: uart_mem_loader

Overview:
- Serial boot loader that sits directly upstream of the unified 64-bit program/data memory on the board top.
- Receives a length-prefixed image over an 8N1 UART line and assembles little-endian bytes into 64-bit words.
- Writes each word into memory through a single-cycle write port and raises done when the image is complete, so the CPU/LED stage can start consuming memory.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults).
- ADDR_W, 12, memory word-address width.
- DEPTH, 3000, number of 64-bit words in the memory; largest legal image length.

Ports:
- CLOCK_50  input  1  system clock; all logic on the rising edge.
- KEY0  input  1  asynchronous active-low reset.
- uart_rx  input  1  asynchronous serial input; idles high.
- mem_we  output  1  one-cycle write strobe.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  64  word to write.
- words_loaded  output  ADDR_W+1  count of words written so far.
- done  output  1  image fully written; sticky until reset.
- frame_err  output  1  sticky; a stop bit sampled low.
- size_err  output  1  sticky; header length exceeded DEPTH.

Behaviour:
- Reset (KEY0 low, asynchronous) clears every output to 0. It also clears the receiver and loader state, the byte index and the word accumulator. The 2-FF synchronizer is preset to 1 (idle). Reset mid-frame or mid-word discards everything received so far.
- Synchronizer: uart_rx passes through 2 flops. All receiver logic uses the synchronized value.
- Receiver FSM has states R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: a synchronized low moves to R_START and clears the bit timer.
  - R_START: at CLKS_PER_BIT/2 clocks, sample the line. If high, treat it as a false start and return to R_IDLE. If low, go to R_DATA.
  - R_DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
  - R_STOP: sample after CLKS_PER_BIT. If high, byte_valid pulses for one cycle. If low, set frame_err and drop the byte. Return to R_IDLE in both cases.
  - A new start bit is accepted from the cycle after the R_STOP sample.
- Loader FSM has states L_HDR0, L_HDR1, L_DATA, L_DONE, L_ERR, and acts only on byte_valid.
  - L_HDR0: latch len[7:0], go to L_HDR1.
  - L_HDR1: latch len[15:8]. If len == 0, go to L_DONE. If len > DEPTH, set size_err and go to L_ERR. Otherwise go to L_DATA.
  - L_DATA: byte k of the current word (k = 0..7) goes into wdata[8k+7:8k]. On byte 7, the next cycle asserts mem_we for exactly 1 cycle, with mem_wdata = the assembled word and mem_addr = the current address.
  - After each write, the address increments and words_loaded increments in the same cycle. When words_loaded reaches len, go to L_DONE.
  - L_DONE: done = 1. All further bytes are ignored and mem_we is never asserted again.
  - L_ERR: all further bytes are ignored and memory is never written.
- Latency: mem_we rises 1 clock after the byte_valid of the 8th byte, which is roughly CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after the start edge. done rises on the same cycle as the final mem_we.
- A frame-errored byte does not advance the byte index. The image continues with the next good byte, so the host must resend.
- mem_addr and mem_wdata hold their last values when mem_we is low.
- Address wrap cannot occur, because len ≤ DEPTH ≤ 2^ADDR_W.

Test Plan:
Bench parameters: CLK_HZ=1000000, BAUD=100000, so CLKS_PER_BIT = 10.
- Send bytes 01 00 then 11 22 33 44 55 66 77 88 -> exactly one mem_we pulse with mem_addr=0 and mem_wdata=64'h8877665544332211; done=1 on that cycle; words_loaded=1.
- Send a header for len=3 and then 24 bytes with values 00..17 -> 3 mem_we pulses at addresses 0, 1, 2; the word at address 2 = 64'h1716151413121110; done is asserted only after the third pulse.
- Send a header 00 00 -> done=1 with no mem_we pulse; any following bytes produce no writes.
- Send a header B9 0B (len=3001, which exceeds DEPTH=3000), then 8 data bytes -> size_err=1, no mem_we, done=0.
- Hold uart_rx low for 4 clocks only (a glitch), then send a valid image -> the glitch is rejected and the image loads normally. Separately, send one byte with its stop bit low -> frame_err=1, that byte is not counted, and the word completes after 8 good bytes.
- Pull KEY0 low after 5 data bytes of a len=1 image, release it, then send a full len=1 image -> all outputs read 0 during reset, and the single write has mem_addr=0 with only the new data.

Source files
------------

// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Serial boot loader. Receives an 8N1 UART stream made of a 16-bit
//   little-endian word count followed by the image bytes. It packs the bytes
//   little-endian into 64-bit words and writes each word through a
//   single-cycle memory write port.
//
// Ports
//   CLOCK_50     : system clock, rising edge
//   KEY0         : asynchronous active-low reset
//   uart_rx      : asynchronous serial input, idles high
//   mem_we       : one-cycle write strobe
//   mem_addr     : word address of the write
//   mem_wdata    : 64-bit word being written
//   words_loaded : number of words written so far
//   done         : image complete (sticky)
//   frame_err    : a stop bit was sampled low (sticky)
//   size_err     : header length exceeded DEPTH (sticky)
module uart_mem_loader #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 3000
) (
    input  logic              CLOCK_50,
    input  logic              KEY0,
    input  logic              uart_rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [ADDR_W:0]   words_loaded,
    output logic              done,
    output logic              frame_err,
    output logic              size_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW           = $clog2(CLKS_PER_BIT + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [15:0]   DEPTH_L   = 16'(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
    typedef enum logic [2:0] {L_HDR0, L_HDR1, L_DATA, L_DONE, L_ERR} l_state_t;

    // ------------------------------------------------------------------
    // Input synchronizer (preset to idle level)
    // ------------------------------------------------------------------
    logic rx_meta, rx_s;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    r_state_t       r_state, r_next;
    logic [TW-1:0]  timer;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift;
    logic [7:0]     rx_byte;
    logic           byte_valid;
    logic           tick_half, tick_bit;

    assign tick_half = (timer == HALF_LAST);
    assign tick_bit  = (timer == BIT_LAST);

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (!rx_s) r_next = R_START;
            // A line that is high again at mid-start-bit is a glitch.
            R_START: if (tick_half) r_next = rx_s ? R_IDLE : R_DATA;
            R_DATA:  if (tick_bit && bit_cnt == 3'd7) r_next = R_STOP;
            R_STOP:  if (tick_bit) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    timer   <= '0;
                    bit_cnt <= '0;
                end
                R_START: timer <= tick_half ? '0 : timer + 1'b1;
                R_DATA: begin
                    timer <= tick_bit ? '0 : timer + 1'b1;
                    if (tick_bit) begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                R_STOP: begin
                    timer <= tick_bit ? '0 : timer + 1'b1;
                    if (tick_bit) begin
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end
                end
                default: timer <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    l_state_t     l_state, l_next;
    logic [15:0]  len;
    logic [15:0]  len_full;
    logic [15:0]  wl_inc;
    logic [2:0]   byte_idx;
    logic [63:0]  acc;

    assign len_full = {rx_byte, len[7:0]};
    assign wl_inc   = 16'(words_loaded) + 16'd1;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) l_state <= L_HDR0;
        else       l_state <= l_next;
    end

    always_comb begin
        l_next = l_state;
        if (byte_valid) begin
            case (l_state)
                L_HDR0: l_next = L_HDR1;
                L_HDR1: begin
                    if (len_full == 16'd0)         l_next = L_DONE;
                    else if (len_full > DEPTH_L)   l_next = L_ERR;
                    else                           l_next = L_DATA;
                end
                L_DATA: if (byte_idx == 3'd7 && wl_inc == len) l_next = L_DONE;
                default: l_next = l_state;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            len          <= '0;
            byte_idx     <= '0;
            acc          <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
            size_err     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            // Registered so that done rises together with the final mem_we.
            if (l_next == L_DONE) done <= 1'b1;
            if (byte_valid) begin
                case (l_state)
                    L_HDR0: len[7:0] <= rx_byte;
                    L_HDR1: begin
                        len[15:8] <= rx_byte;
                        if (len_full > DEPTH_L) size_err <= 1'b1;
                    end
                    L_DATA: begin
                        acc[{byte_idx, 3'b000} +: 8] <= rx_byte;
                        byte_idx <= byte_idx + 3'd1;
                        if (byte_idx == 3'd7) begin
                            // The eighth byte bypasses the accumulator so the
                            // write lands one clock after its byte_valid.
                            mem_we       <= 1'b1;
                            mem_wdata    <= {rx_byte, acc[55:0]};
                            mem_addr     <= words_loaded[ADDR_W-1:0];
                            words_loaded <= words_loaded + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
module tb_uart_mem_loader;

    localparam int CPB    = 10;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              uart_rx = 1'b1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [ADDR_W:0]   words_loaded;
    logic              done, frame_err, size_err;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
        logic              dn;
        logic [ADDR_W:0]   wl;
    } wr_t;

    wr_t exp_q[$];

    uart_mem_loader #(
        .CLK_HZ(1000000),
        .BAUD  (100000),
        .ADDR_W(ADDR_W),
        .DEPTH (3000)
    ) dut (
        .CLOCK_50    (clk),
        .KEY0        (rst_n),
        .uart_rx     (uart_rx),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .words_loaded(words_loaded),
        .done        (done),
        .frame_err   (frame_err),
        .size_err    (size_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", 64'(mem_addr), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                    chk("wr_data", mem_wdata, e.data);
                    chk("wr_done", 64'(done), 64'(e.dn));
                    chk("wr_words_loaded", 64'(words_loaded), 64'(e.wl));
                end
            end
        end
    end

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [63:0] d,
                             input logic dn, input logic [ADDR_W:0] wl);
        wr_t e;
        e.addr = a; e.data = d; e.dn = dn; e.wl = wl;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        #2;
        chk("rst_outputs",
            {mem_we, done, frame_err, size_err, 60'(mem_addr)} | mem_wdata | 64'(words_loaded),
            64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = ~bad_stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i), 1'b0);
    endtask

    task automatic queue_drained(input string name);
        repeat (3 * CPB) @(negedge clk);
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        // 1: single word
        do_reset();
        expect_wr(12'd0, 64'h8877665544332211, 1'b1, 13'd1);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_seq(8'h11, 1); send_seq(8'h22, 1); send_seq(8'h33, 1); send_seq(8'h44, 1);
        send_seq(8'h55, 1); send_seq(8'h66, 1); send_seq(8'h77, 1); send_seq(8'h88, 1);
        queue_drained("t1_writes");
        chk("t1_done", 64'(done), 64'd1);

        // 2: three words
        do_reset();
        expect_wr(12'd0, 64'h0706050403020100, 1'b0, 13'd1);
        expect_wr(12'd1, 64'h0F0E0D0C0B0A0908, 1'b0, 13'd2);
        expect_wr(12'd2, 64'h1716151413121110, 1'b1, 13'd3);
        send_byte(8'h03, 0); send_byte(8'h00, 0);
        send_seq(8'h00, 16);
        chk("t2_done_before_last", 64'(done), 64'd0);
        send_seq(8'h10, 8);
        queue_drained("t2_writes");
        chk("t2_words", 64'(words_loaded), 64'd3);

        // 3: zero-length image
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("t3_done", 64'(done), 64'd1);
        send_seq(8'h40, 8);
        queue_drained("t3_no_writes");
        chk("t3_words", 64'(words_loaded), 64'd0);

        // 4: oversized header (3001 > 3000)
        do_reset();
        send_byte(8'hB9, 0); send_byte(8'h0B, 0);
        send_seq(8'h50, 8);
        queue_drained("t4_no_writes");
        chk("t4_size_err", 64'(size_err), 64'd1);
        chk("t4_done", 64'(done), 64'd0);

        // 5a: short glitch then a good image
        do_reset();
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        expect_wr(12'd0, 64'hA7A6A5A4A3A2A1A0, 1'b1, 13'd1);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_seq(8'hA0, 8);
        queue_drained("t5a_writes");
        chk("t5a_frame_err", 64'(frame_err), 64'd0);

        // 5b: one bad stop bit inside the word
        do_reset();
        expect_wr(12'd0, 64'h0807060504030201, 1'b1, 13'd1);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_seq(8'h01, 3);
        send_byte(8'hFF, 1);
        chk("t5b_frame_err", 64'(frame_err), 64'd1);
        send_seq(8'h04, 5);
        queue_drained("t5b_writes");
        chk("t5b_done", 64'(done), 64'd1);

        // 6: reset in the middle of an image
        do_reset();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_seq(8'hE0, 5);
        do_reset();
        expect_wr(12'd0, 64'hC7C6C5C4C3C2C1C0, 1'b1, 13'd1);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_seq(8'hC0, 8);
        queue_drained("t6_writes");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
